// File: rtl/matrix_loader.sv
// matrix_loader: collects a serial element stream into two packed 5x5 operand
// matrices (A then B) and presents them as a pair to the downstream sum stage.
module matrix_loader #(
    parameter int ELEM_W = 8,
    parameter int N_ELEM = 25
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ELEM_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_ELEM*ELEM_W-1:0] matrix_a,
    output logic [N_ELEM*ELEM_W-1:0] matrix_b,
    output logic [4:0]               elem_idx,
    output logic                     loading_b
);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(N_ELEM - 1);

    state_t state;
    logic   wr_a;
    logic   wr_b;

    // Ready depends on state only, so upstream never sees a combinational
    // path from its own valid back to ready.
    assign in_ready = (state != HOLD);
    assign wr_a     = in_valid && (state == LOAD_A);
    assign wr_b     = in_valid && (state == LOAD_B);

    // Sequencing FSM: element counter, A/B phase and output handshake.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state     <= LOAD_A;
            elem_idx  <= '0;
            loading_b <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (in_valid) begin
                        if (elem_idx == LAST_IDX) begin
                            elem_idx  <= '0;
                            state     <= LOAD_B;
                            loading_b <= 1'b1;
                        end else begin
                            elem_idx <= elem_idx + 5'd1;
                        end
                    end
                end
                LOAD_B: begin
                    if (in_valid) begin
                        if (elem_idx == LAST_IDX) begin
                            elem_idx  <= '0;
                            state     <= HOLD;
                            out_valid <= 1'b1;
                        end else begin
                            elem_idx <= elem_idx + 5'd1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= LOAD_A;
                        out_valid <= 1'b0;
                        loading_b <= 1'b0;
                        elem_idx  <= '0;
                    end
                end
                default: begin
                    state     <= LOAD_A;
                    elem_idx  <= '0;
                    loading_b <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Matrix storage: each accepted beat lands in the slot selected by
    // elem_idx; contents persist between pairs and are only zeroed on abort.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            matrix_a <= '0;
            matrix_b <= '0;
        end else if (wr_a) begin
            matrix_a[elem_idx*ELEM_W +: ELEM_W] <= in_data;
        end else if (wr_b) begin
            matrix_b[elem_idx*ELEM_W +: ELEM_W] <= in_data;
        end
    end

endmodule

// File: tb/tb_matrix_loader.sv
// Self-checking bench for matrix_loader: scoreboard of expected matrix pairs,
// one task per scenario.
module tb_matrix_loader;

    localparam int ELEM_W = 8;
    localparam int N_ELEM = 25;
    localparam int MW     = N_ELEM * ELEM_W;

    typedef struct packed {
        logic [MW-1:0] a;
        logic [MW-1:0] b;
    } pair_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [ELEM_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [MW-1:0]     matrix_a;
    logic [MW-1:0]     matrix_b;
    logic [4:0]        elem_idx;
    logic              loading_b;

    int    n_checks = 0;
    int    n_fail   = 0;
    pair_t sb_q[$];

    matrix_loader #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .matrix_a  (matrix_a),
        .matrix_b  (matrix_b),
        .elem_idx  (elem_idx),
        .loading_b (loading_b)
    );

    always #5 clk = ~clk;

    // advance one edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // drive 50 continuous beats (A then B); no checking
    task automatic drive_pair(input logic [MW-1:0] a, input logic [MW-1:0] b);
        in_valid = 1'b1;
        for (int i = 0; i < 2*N_ELEM; i++) begin
            in_data = (i < N_ELEM) ? a[i*ELEM_W +: ELEM_W] : b[(i-N_ELEM)*ELEM_W +: ELEM_W];
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        // load 10 A elements, then reset mid-load with a beat in flight
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin in_data = 8'(i + 1); tick(); end
        n_checks++; if (elem_idx !== 5'd10) begin n_fail++; $display("FAIL reset_preload_idx: got %0d want 10", elem_idx); end
        rst = 1'b1; in_data = 8'hAA;
        tick(); tick();
        rst = 1'b0; in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); end
        n_checks++; if (elem_idx !== 5'd0) begin n_fail++; $display("FAIL rst_mid_elem_idx: got %0d want 0", elem_idx); end
        n_checks++; if (loading_b !== 1'b0) begin n_fail++; $display("FAIL rst_mid_loading_b: got %b want 0", loading_b); end
        n_checks++; if (matrix_a !== '0) begin n_fail++; $display("FAIL rst_mid_matrix_a: got %h want 0", matrix_a); end
        n_checks++; if (matrix_b !== '0) begin n_fail++; $display("FAIL rst_mid_matrix_b: got %h want 0", matrix_b); end
    endtask

    task automatic test_full_pair();
        pair_t exp_p;
        pair_t got;
        for (int i = 0; i < N_ELEM; i++) begin
            exp_p.a[i*ELEM_W +: ELEM_W] = 8'(i);
            exp_p.b[i*ELEM_W +: ELEM_W] = 8'(100 + i);
        end
        sb_q.push_back(exp_p);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 2*N_ELEM; i++) begin
            in_data = (i < N_ELEM) ? 8'(i) : 8'(100 + i - N_ELEM);
            if (i == 2*N_ELEM-1) begin
                n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_early_valid: got %b want 0", out_valid); end
            end
            tick();
        end
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL full_out_valid: got %b want 1", out_valid);
        end else begin
            got = sb_q.pop_front();
            n_checks++; if (matrix_a !== got.a) begin n_fail++; $display("FAIL full_matrix_a: got %h want %h", matrix_a, got.a); end
            n_checks++; if (matrix_b !== got.b) begin n_fail++; $display("FAIL full_matrix_b: got %h want %h", matrix_b, got.b); end
        end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_valid_one_cycle: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_after: got %b want 1", in_ready); end
        n_checks++; if (elem_idx !== 5'd0) begin n_fail++; $display("FAIL full_idx_after: got %0d want 0", elem_idx); end
        n_checks++; if (loading_b !== 1'b0) begin n_fail++; $display("FAIL full_loading_b_after: got %b want 0", loading_b); end
    endtask

    task automatic test_bursty();
        pair_t      exp_p;
        pair_t      got;
        int         sent = 0;
        int         cyc  = 0;
        logic [4:0] exp_idx = 5'd0;
        logic       v;
        for (int i = 0; i < N_ELEM; i++) begin
            exp_p.a[i*ELEM_W +: ELEM_W] = 8'(255 - i);
            exp_p.b[i*ELEM_W +: ELEM_W] = 8'(255 - N_ELEM - i);
        end
        sb_q.push_back(exp_p);
        out_ready = 1'b1;
        while (sent < 2*N_ELEM && cyc < 2000) begin
            v        = 1'($urandom_range(0, 1));
            in_valid = v;
            in_data  = 8'(255 - sent);
            tick();
            cyc++;
            if (v) begin
                sent++;
                exp_idx = (exp_idx == 5'd24) ? 5'd0 : exp_idx + 5'd1;
            end
            n_checks++; if (elem_idx !== exp_idx) begin n_fail++; $display("FAIL bursty_idx cyc %0d: got %0d want %0d", cyc, elem_idx, exp_idx); end
        end
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bursty_out_valid: got %b want 1", out_valid);
        end else begin
            got = sb_q.pop_front();
            n_checks++; if (matrix_a !== got.a) begin n_fail++; $display("FAIL bursty_matrix_a: got %h want %h", matrix_a, got.a); end
            n_checks++; if (matrix_b !== got.b) begin n_fail++; $display("FAIL bursty_matrix_b: got %h want %h", matrix_b, got.b); end
        end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bursty_accept: got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        pair_t exp_p;
        pair_t got;
        int    t = 0;
        for (int i = 0; i < N_ELEM; i++) begin
            exp_p.a[i*ELEM_W +: ELEM_W] = 8'($urandom);
            exp_p.b[i*ELEM_W +: ELEM_W] = 8'($urandom);
        end
        sb_q.push_back(exp_p);
        out_ready = 1'b0;
        drive_pair(exp_p.a, exp_p.b);
        while (!out_valid && t < 100) begin tick(); t++; end
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_out_valid timeout: got %b want 1", out_valid);
            return;
        end
        got = sb_q.pop_front();
        in_valid = 1'b1; in_data = 8'h55;
        for (int c = 0; c < 20; c++) begin
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready c%0d: got %b want 0", c, in_ready); end
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid c%0d: got %b want 1", c, out_valid); end
            n_checks++; if (matrix_a !== got.a || matrix_b !== got.b) begin n_fail++; $display("FAIL bp_frozen c%0d: got a=%h want a=%h", c, matrix_a, got.a); end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_accept_valid: got %b want 0", out_valid); end
        n_checks++; if (matrix_a !== got.a) begin n_fail++; $display("FAIL bp_no_write_in_hold: got %h want %h", matrix_a, got.a); end
        tick();
        in_valid = 1'b0;
        n_checks++; if (matrix_a[7:0] !== 8'h55) begin n_fail++; $display("FAIL bp_first_beat: got %h want 55", matrix_a[7:0]); end
        n_checks++; if (elem_idx !== 5'd1) begin n_fail++; $display("FAIL bp_idx_after: got %0d want 1", elem_idx); end
        rst = 1'b1; tick(); rst = 1'b0;
    endtask

    task automatic test_boundary();
        pair_t exp_p;
        pair_t got;
        for (int i = 0; i < N_ELEM; i++) begin
            exp_p.a[i*ELEM_W +: ELEM_W] = 8'($urandom_range(1, 254));
            exp_p.b[i*ELEM_W +: ELEM_W] = 8'($urandom_range(1, 254));
        end
        exp_p.a[7:0] = 8'h00; exp_p.a[199:192] = 8'hFF;
        exp_p.b[7:0] = 8'hFF; exp_p.b[199:192] = 8'h00;
        sb_q.push_back(exp_p);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < N_ELEM; i++) begin in_data = exp_p.a[i*ELEM_W +: ELEM_W]; tick(); end
        n_checks++; if (elem_idx !== 5'd0) begin n_fail++; $display("FAIL wrap_idx: got %0d want 0", elem_idx); end
        n_checks++; if (loading_b !== 1'b1) begin n_fail++; $display("FAIL wrap_loading_b: got %b want 1", loading_b); end
        for (int i = 0; i < N_ELEM; i++) begin in_data = exp_p.b[i*ELEM_W +: ELEM_W]; tick(); end
        in_valid = 1'b0;
        n_checks++; if (matrix_b[199:192] !== 8'h00) begin n_fail++; $display("FAIL b24_bits: got %h want 00", matrix_b[199:192]); end
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bnd_out_valid: got %b want 1", out_valid);
        end else begin
            got = sb_q.pop_front();
            n_checks++; if (matrix_a !== got.a) begin n_fail++; $display("FAIL bnd_matrix_a: got %h want %h", matrix_a, got.a); end
            n_checks++; if (matrix_b !== got.b) begin n_fail++; $display("FAIL bnd_matrix_b: got %h want %h", matrix_b, got.b); end
        end
        tick();
    endtask

    task automatic test_clear();
        pair_t exp_p;
        pair_t got;
        int    t = 0;
        in_valid = 1'b1;
        for (int i = 0; i < N_ELEM + 7; i++) begin in_data = 8'(i + 3); tick(); end
        n_checks++; if (elem_idx !== 5'd7 || loading_b !== 1'b1) begin n_fail++; $display("FAIL clr_pre: got idx %0d lb %b want 7 1", elem_idx, loading_b); end
        clear = 1'b1; in_data = 8'hC3;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        n_checks++; if (loading_b !== 1'b0) begin n_fail++; $display("FAIL clr_loading_b: got %b want 0", loading_b); end
        n_checks++; if (elem_idx !== 5'd0) begin n_fail++; $display("FAIL clr_idx: got %0d want 0", elem_idx); end
        n_checks++; if (matrix_a !== '0 || matrix_b !== '0) begin n_fail++; $display("FAIL clr_zero: got a=%h b=%h want 0", matrix_a, matrix_b); end
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_hs: got rdy %b vld %b want 1 0", in_ready, out_valid); end
        for (int i = 0; i < N_ELEM; i++) begin
            exp_p.a[i*ELEM_W +: ELEM_W] = 8'($urandom);
            exp_p.b[i*ELEM_W +: ELEM_W] = 8'($urandom);
        end
        sb_q.push_back(exp_p);
        out_ready = 1'b0;
        drive_pair(exp_p.a, exp_p.b);
        while (!out_valid && t < 100) begin tick(); t++; end
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL clr_reload_valid: got %b want 1", out_valid);
        end else begin
            got = sb_q.pop_front();
            n_checks++; if (matrix_a !== got.a) begin n_fail++; $display("FAIL clr_matrix_a: got %h want %h", matrix_a, got.a); end
            n_checks++; if (matrix_b !== got.b) begin n_fail++; $display("FAIL clr_matrix_b: got %h want %h", matrix_b, got.b); end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_pair();
        test_bursty();
        test_backpressure();
        test_boundary();
        test_clear();
        n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_left: got %0d want 0", sb_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_loader.md
Name: matrix_loader

Overview:
- Upstream stage of the 5x5 matrix adder: assembles operands A and B from a serial 8-bit element stream.
- Input is a valid/ready handshake, one element per beat, 25 elements of A followed by 25 of B.
- Presents both packed 200-bit matrices with a valid/ready handshake to the downstream sum stage and holds them stable until accepted.
- Element i (row-major, i = row*5 + col) occupies bits [i*8 +: 8] of each packed matrix.

Parameters:
- ELEM_W, 8, element width in bits.
- N_ELEM, 25, elements per matrix (5x5).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous abort; same effect as rst.
- in_valid  in  1  in_data holds a valid element.
- in_ready  out  1  loader can accept an element this cycle.
- in_data  in  ELEM_W  element value.
- out_valid  out  1  matrix_a and matrix_b are complete and valid.
- out_ready  in  1  downstream accepts the matrix pair.
- matrix_a  out  N_ELEM*ELEM_W  packed operand A (200 bits).
- matrix_b  out  N_ELEM*ELEM_W  packed operand B (200 bits).
- elem_idx  out  5  index of the next element to be written (0..24).
- loading_b  out  1  0 while filling A, 1 while filling B.

Behaviour:
- One clock; reset is synchronous and active-high; all state updates on the rising edge of clk.
- Reset / clear (rst has priority over clear; both over all other activity):
  - state = LOAD_A, elem_idx = 0, loading_b = 0, out_valid = 0.
  - matrix_a = 0, matrix_b = 0.
  - An in-flight beat in the same cycle is discarded.
- States: LOAD_A, LOAD_B, HOLD.
- in_ready = 1 in LOAD_A and LOAD_B, 0 in HOLD. It is decoded from state only and never depends on in_valid.
- A transfer occurs when in_valid && in_ready on a clock edge. No transfer means no state change; in_valid may idle at 0 for any number of cycles.
- LOAD_A transfer:
  - Writes in_data to matrix_a[elem_idx*8 +: 8].
  - elem_idx < 24: elem_idx increments.
  - elem_idx == 24: elem_idx wraps to 0, state goes to LOAD_B, loading_b = 1.
- LOAD_B transfer:
  - Writes to matrix_b[elem_idx*8 +: 8].
  - elem_idx == 24: elem_idx wraps to 0, state goes to HOLD, out_valid = 1 from the next cycle.
- HOLD:
  - out_valid = 1; matrix_a and matrix_b are frozen.
  - out_valid && out_ready: next cycle out_valid = 0, state = LOAD_A, loading_b = 0, elem_idx = 0.
  - out_ready held 0: stay in HOLD indefinitely.
- Latency and throughput:
  - Last B beat at edge k gives out_valid = 1 after edge k.
  - Minimum period is 50 input beats + 1 HOLD cycle per matrix pair.
  - In the cycle after acceptance, in_ready = 1 again.
- Matrix registers are not cleared between pairs. Elements are overwritten as new beats arrive, so partially loaded contents are visible but not valid while out_valid = 0.
- out_ready while out_valid = 0 is ignored.
- No arithmetic and no saturation: data passes bit-exact.
- elem_idx never exceeds 24.

Test Plan:
- Reset: assert rst 2 cycles mid-load (A element 10) -> out_valid = 0, in_ready = 1, elem_idx = 0, loading_b = 0, matrix_a = matrix_b = 0.
- Full pair, continuous in_valid: A elements = i, B elements = 100+i, out_ready = 1 -> out_valid high exactly 1 cycle after beat 50. matrix_a[i*8 +: 8] = i, matrix_b[i*8 +: 8] = 100+i. Next cycle returns to LOAD_A, in_ready = 1.
- Bursty input: in_valid toggles pseudo-randomly (~50%), data 0xFF - i -> same packed result, no element skipped or duplicated. elem_idx increments only on transfer cycles.
- Backpressure: out_ready = 0 for 20 cycles in HOLD while in_valid = 1, in_data = 0x55 -> in_ready = 0 and matrices unchanged throughout. out_ready = 1 then gives one handshake, and the next 0x55 beat lands in matrix_a element 0.
- Boundary/wrap: after element 24 of A, elem_idx = 0 and loading_b = 1. Element 24 of B lands at bits [199:192]. Values 0x00 and 0xFF at elements 0 and 24 are exact.
- Clear mid-B (B element 7) -> next cycle LOAD_A, elem_idx = 0, matrices zeroed. A new full pair loads correctly afterwards.
